// File: rtl/bram_stream_reader.sv
// Burst read initiator for one BRAM port: streams words out with TLAST.
// Optional BRAM_STREAM_READER_STRIDE_EN adds a per-burst address stride.
module bram_stream_reader #(
  parameter  int DW      = 32,
  parameter  int DEPTH   = 1024,
  parameter  int LATENCY = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int FD      = LATENCY + 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
`ifdef BRAM_STREAM_READER_STRIDE_EN
  input  logic [AW-1:0] cmd_stride,
`endif
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout,
  output logic          bram_regce,
  output logic          bram_rst,
  output logic          busy
);

  localparam int CW = $clog2(FD + 1);
  localparam int PW = $clog2(FD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_started;
  logic [AW:0]         r_rem;
  logic [AW-1:0]       r_addr;
  logic [LATENCY-1:0]  r_pv;
  logic [LATENCY-1:0]  r_pl;
  logic [CW-1:0]       r_infl;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_rd;
  logic [PW-1:0]       r_wr;
  logic [DW-1:0]       r_mem [FD];
  logic [FD-1:0]       r_lmem;

  logic                w_accept;
  logic                w_credit;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_last_issue;
  logic [AW-1:0]       w_stride;
  logic [AW:0]         w_sum;
  logic [AW-1:0]       w_addr_nxt;

`ifdef BRAM_STREAM_READER_STRIDE_EN
  logic [AW-1:0]       r_stride;
  logic [AW-1:0]       w_stride_in;

  // Pre-reduce stride so one conditional subtract keeps the address in range
  assign w_stride_in = ({1'b0, cmd_stride} >= (AW+1)'(DEPTH))
                     ? AW'({1'b0, cmd_stride} - (AW+1)'(DEPTH))
                     : cmd_stride;
  assign w_stride    = r_stride;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_stride <= '0;
    else if (w_accept) r_stride <= w_stride_in;
  end
`else
  assign w_stride = AW'(1);
`endif

  assign cmd_ready    = r_started && (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign w_accept     = cmd_ready && cmd_valid && (cmd_len != '0);
  assign w_credit     = ({1'b0, r_infl} + {1'b0, r_cnt}) < (CW+1)'(FD);
  assign w_issue      = (r_state == S_READ) && (r_rem != '0) && w_credit;
  assign w_last_issue = w_issue && (r_rem == (AW+1)'(1));
  assign w_push       = r_pv[LATENCY-1];
  assign w_pop        = m_tvalid && m_tready;

  assign w_sum        = {1'b0, r_addr} + {1'b0, w_stride};
  assign w_addr_nxt   = (w_sum >= (AW+1)'(DEPTH))
                      ? AW'(w_sum - (AW+1)'(DEPTH))
                      : AW'(w_sum);

  assign m_tvalid   = (r_cnt != '0);
  assign m_tdata    = r_mem[r_rd];
  assign m_tlast    = m_tvalid && r_lmem[r_rd];
  assign bram_en    = w_issue;
  assign bram_addr  = r_addr;
  assign bram_we    = 1'b0;
  assign bram_din   = '0;
  assign bram_regce = 1'b1;
  assign bram_rst   = 1'b0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ:  if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_infl == '0 &&
                   (r_cnt == '0 || (r_cnt == CW'(1) && w_pop)))
                 w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
      r_rem     <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      if (w_accept) begin
        r_rem  <= cmd_len;
        r_addr <= cmd_addr;
      end else if (w_issue) begin
        r_rem  <= r_rem - (AW+1)'(1);
        r_addr <= w_addr_nxt;
      end
    end
  end

  // Valid/last travel alongside the read so data is caught at the right cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pv   <= '0;
      r_pl   <= '0;
      r_infl <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pl[0] <= w_last_issue;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
      if (w_issue && !w_push)      r_infl <= r_infl + CW'(1);
      else if (!w_issue && w_push) r_infl <= r_infl - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_lmem <= '0;
      for (int i = 0; i < FD; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr]  <= bram_dout;
        r_lmem[r_wr] <= r_pl[LATENCY-1];
        r_wr <= (r_wr == PW'(FD-1)) ? '0 : r_wr + PW'(1);
      end
      if (w_pop)
        r_rd <= (r_rd == PW'(FD-1)) ? '0 : r_rd + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a behavioural BRAM (mem[i]=i).
// Stride scenario runs only when BRAM_STREAM_READER_STRIDE_EN is defined.
module tb_bram_stream_reader;

  localparam int DW      = 32;
`ifdef BRAM_STREAM_READER_STRIDE_EN
  localparam int DEPTH   = 8;
`else
  localparam int DEPTH   = 1024;
`endif
  localparam int LATENCY = 2;
  localparam int AW      = $clog2(DEPTH);
  localparam int FD      = LATENCY + 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          bram_regce;
  logic          bram_rst;
  logic          busy;
`ifdef BRAM_STREAM_READER_STRIDE_EN
  logic [AW-1:0] cmd_stride = AW'(1);
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int issued = 0;
  int popped = 0;
  logic [DW:0] exp_q [$];

  always #5 clk = ~clk;

  bram_stream_reader #(.DW(DW), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef BRAM_STREAM_READER_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout),
    .bram_regce(bram_regce), .bram_rst(bram_rst),
    .busy(busy)
  );

  // Behavioural BRAM: mem[i] = i, registered output stage when LATENCY=2
  logic [DW-1:0] b_r1 = '0;
  logic [DW-1:0] b_r2 = '0;
  always @(posedge clk) begin
    if (bram_en) b_r1 <= DW'(bram_addr);
    b_r2 <= b_r1;
  end
  assign bram_dout = (LATENCY == 1) ? b_r1 : b_r2;

  // Output monitor: scoreboard, stall stability and credit bound
  logic          stalled = 1'b0;
  logic [DW-1:0] p_data;
  logic          p_last;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rstn) begin
      issued  = 0;
      popped  = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!m_tvalid || m_tdata !== p_data || m_tlast !== p_last) begin
          errors++;
          $display("FAIL stall_hold got v=%0b d=%0d l=%0b need v=1 d=%0d l=%0b",
                   m_tvalid, m_tdata, m_tlast, p_data, p_last);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got d=%0d l=%0b need none",
                   m_tdata, m_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            errors++;
            $display("FAIL beat got d=%0d l=%0b need d=%0d l=%0b",
                     m_tdata, m_tlast, e[DW-1:0], e[DW]);
          end
        end
        pops++;
      end
      stalled = m_tvalid && !m_tready;
      p_data  = m_tdata;
      p_last  = m_tlast;
      if (bram_en) issued++;
      if (m_tvalid && m_tready) popped++;
      checks++;
      if (issued - popped > FD) begin
        errors++;
        $display("FAIL fifo_overflow got outstanding=%0d need <=%0d",
                 issued - popped, FD);
      end
    end
  end

  task automatic send_cmd(input int addr, input int len, input int stride);
    int a;
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_ready_wait got 0 need 1");
    end
    cmd_addr  = AW'(addr);
    cmd_len   = (AW+1)'(len);
`ifdef BRAM_STREAM_READER_STRIDE_EN
    cmd_stride = AW'(stride);
`endif
    cmd_valid = 1'b1;
    a = addr;
    for (int k = 0; k < len; k++) begin
      exp_q.push_back({(k == len - 1), DW'(a)});
      a = (a + stride) % DEPTH;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout got busy=%0b left=%0d need 0 0",
               busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, m_tvalid, m_tlast, bram_en, busy} !== 5'b0 ||
        m_tdata !== '0 || bram_addr !== '0) begin
      errors++;
      $display("FAIL reset_vals got rdy=%0b v=%0b l=%0b en=%0b busy=%0b d=%0d a=%0d need all 0",
               cmd_ready, m_tvalid, m_tlast, bram_en, busy, m_tdata, bram_addr);
    end
    checks++;
    if ({bram_we, bram_regce, bram_rst} !== 3'b010 || bram_din !== '0) begin
      errors++;
      $display("FAIL bram_consts got we=%0b ce=%0b rst=%0b din=%0d need 0 1 0 0",
               bram_we, bram_regce, bram_rst, bram_din);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_early got %0b need 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise got %0b need 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    int beat;
    int lastk;
    m_tready = 1'b1;
    send_cmd((DEPTH > 10) ? 10 : 1, 4, 1);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (m_tvalid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != LATENCY + 1) begin
      errors++;
      $display("FAIL first_latency got %0d need %0d", lat, LATENCY + 1);
    end
    lastk = -1;
    for (beat = 0; beat < 10; beat++) begin
      if (m_tvalid && m_tlast) begin
        lastk = beat;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lastk != 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL last_position got beat=%0d busy=%0b need 3 1", lastk, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall got %0b need 0", busy);
    end
    wait_idle(20);
  endtask

  task automatic test_wrap();
    m_tready = 1'b1;
    send_cmd(DEPTH - 2, 4, 1);
    wait_idle(50);
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    pops = 0;
    send_cmd(50 % DEPTH, 8, 1);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      m_tready = pat[n % 4];
      @(posedge clk); #1;
      n++;
    end
    m_tready = 1'b1;
    wait_idle(20);
    checks++;
    if (pops != 8) begin
      errors++;
      $display("FAIL bp_count got %0d need 8", pops);
    end
  endtask

  task automatic test_zero_len();
    m_tready = 1'b1;
    @(posedge clk); #1;
    cmd_addr  = AW'(3);
    cmd_len   = '0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({cmd_ready, bram_en, m_tvalid, busy} !== 4'b1000) begin
        errors++;
        $display("FAIL zero_len got rdy=%0b en=%0b v=%0b busy=%0b need 1 0 0 0",
                 cmd_ready, bram_en, m_tvalid, busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_depth();
    pops = 0;
    m_tready = 1'b1;
    send_cmd(5 % DEPTH, DEPTH, 1);
    wait_idle(2 * DEPTH + 50);
    checks++;
    if (pops != DEPTH) begin
      errors++;
      $display("FAIL full_depth got %0d need %0d", pops, DEPTH);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    pops = 0;
    m_tready = 1'b1;
    send_cmd(100 % DEPTH, 16, 1);
    n = 0;
    while (pops < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, m_tvalid, m_tlast, bram_en, busy} !== 5'b0 ||
        m_tdata !== '0 || bram_addr !== '0 || pops < 3) begin
      errors++;
      $display("FAIL mid_reset got rdy=%0b v=%0b l=%0b en=%0b busy=%0b d=%0d a=%0d pops=%0d need 0s pops>=3",
               cmd_ready, m_tvalid, m_tlast, bram_en, busy, m_tdata, bram_addr, pops);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pops = 0;
    send_cmd(0, 2, 1);
    wait_idle(50);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL post_reset_count got %0d need 2", pops);
    end
  endtask

`ifdef BRAM_STREAM_READER_STRIDE_EN
  task automatic test_stride();
    m_tready = 1'b1;
    send_cmd(0, 4, 3);
    wait_idle(50);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_full_depth();
    test_mid_reset();
`ifdef BRAM_STREAM_READER_STRIDE_EN
    test_stride();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side initiator for one port of the team's true-dual-port BRAM; the BRAM port itself stays a passive responder.
- Accepts a burst command (start address, word count) and issues sequential reads on the port.
- Returns the read data as a ready/valid stream with TLAST on the final word.
- Absorbs the fixed BRAM read latency with a credit-controlled skid FIFO, so full downstream backpressure is supported without losing data.

Parameters:
- DW, 32, data width; must match the BRAM.
- DEPTH, 1024, BRAM depth in words; need not be a power of two.
- LATENCY, 2, BRAM read latency in cycles. 1 = low-latency port, 2 = high-performance port. Legal values: 1 or 2.
- AW (localparam), $clog2(DEPTH), address width.
- FD (localparam), LATENCY+2, skid FIFO depth.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous, active-low reset.
- cmd_addr  in  AW  burst start address.
- cmd_len  in  AW+1  word count, 0..DEPTH.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- m_tdata  out  DW  read data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on the last word of the burst.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable; constant 0.
- bram_addr  out  AW  BRAM address.
- bram_din  out  DW  BRAM write data; constant 0.
- bram_dout  in  DW  BRAM read data.
- bram_regce  out  1  BRAM output register enable; constant 1.
- bram_rst  out  1  BRAM output reset; constant 0.
- busy  out  1  high from command accept until the last word is transferred.

Behaviour:
- Reset values: cmd_ready=0, m_tvalid=0, m_tlast=0, m_tdata=0, bram_en=0, bram_addr=0, busy=0. FIFO, in-flight pipeline and counters are all cleared.
- cmd_ready rises on the first clk edge after rstn deasserts.
- States:
  - IDLE: cmd_ready=1. Accept moves to READ. If cmd_len=0, stay in IDLE and produce no output.
  - READ: issue reads. Move to DRAIN in the cycle the last read issues.
  - DRAIN: wait until no reads are in flight, the FIFO is empty and the last beat has been transferred; then go to IDLE. cmd_ready=0 in both READ and DRAIN.
- Issue rule: bram_en=1 in a cycle only if remaining>0 and (inflight + fifo_count) < FD.
  - Each issue decrements remaining and advances the address.
  - Address after DEPTH-1 wraps to 0.
- Pipeline: a LATENCY-deep shift register carries {valid, last} per issued read. Data is captured from bram_dout exactly LATENCY cycles after its bram_en=1 cycle.
- FIFO behaviour:
  - m_tvalid = FIFO not empty.
  - A pop occurs when m_tvalid and m_tready are both high.
  - A simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by construction. The bench asserts that the FIFO is never pushed while full.
- First-word latency with m_tready=1: m_tvalid rises LATENCY+1 cycles after the accept edge. Throughput thereafter is 1 word per cycle.
- Stalls and ordering:
  - m_tready low stalls issue once credits run out.
  - m_tdata, m_tlast and m_tvalid hold stable while stalled.
  - Words are returned in address order.
- busy falls in the cycle after the TLAST handshake.
- cmd_len=DEPTH reads every word exactly once.
- A reset asserted mid-burst aborts immediately. All in-flight data is discarded and the block returns to IDLE after release. BRAM contents are unaffected.

Optional Feature:
- Macro: BRAM_STREAM_READER_STRIDE_EN.
- Defined:
  - Adds input port cmd_stride [AW-1:0], captured at accept.
  - Address advances by stride modulo DEPTH, i.e. (addr+stride) mod DEPTH computed without overflow.
  - Stride 0 reads the same word repeatedly.
- Undefined: port absent; stride is fixed at 1.

Test Plan:
- BRAM preloaded mem[i]=i, LATENCY=2. Command addr=10, len=4, m_tready=1 → m_tvalid high 3 cycles after accept; data 10, 11, 12, 13 on consecutive cycles; m_tlast on 13; busy falls the next cycle.
- addr=DEPTH-2, len=4 → data DEPTH-2, DEPTH-1, 0, 1.
- len=8 with m_tready toggling 1,0,0,1 repeating → all 8 words delivered in order, no duplicates; data held stable during stalls; FIFO never pushed while full.
- len=0 → cmd_ready stays high; no bram_en, no m_tvalid, busy stays 0.
- rstn pulsed low mid-burst (after 3 of 16 words) → all outputs return to reset values; a new command addr=0, len=2 returns 0, 1 with no stale data.
- STRIDE_EN: addr=0, stride=3, len=4, DEPTH=8 → data 0, 3, 6, 1.
